router_fsm_nch: RTL and testbench

Parametrised control FSM for an N-output packet router, successor to the fixed 3-channel router controller.
- Decodes the header address and sequences header, payload and parity loading into the selected output FIFO.
- Handles FIFO-full stalls and per-channel soft reset.
- Adds invalid-address packet dropping and a bounded wait-till-empty timeout.
- Sits between the input byte register/parity block and the N output FIFOs/synchroniser.

---
 rtl/router_fsm_nch_if.sv | 35 +++
 rtl/router_fsm_nch.sv | 85 ++++++++
 tb/tb_router_fsm_nch.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/router_fsm_nch_if.sv
// router_fsm_nch_if: handshake/status bundle between the router FSM and its register block, FIFOs and synchroniser
interface router_fsm_nch_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic              parity_done;
  logic              low_pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_reset;
  logic              busy;
  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              rst_int_reg;
  logic              write_enb_reg;
  logic              drop_state;
  logic [NUM_CH-1:0] ch_sel;
  logic              addr_err;
  logic              wait_timeout;
  modport master (
    output pkt_valid, parity_done, low_pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
    input  busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, drop_state, ch_sel, addr_err, wait_timeout
  );
  modport slave (
    input  pkt_valid, parity_done, low_pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
    output busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, drop_state, ch_sel, addr_err, wait_timeout
  );
endinterface

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: N-channel router control FSM with invalid-address drop and wait-till-empty timeout
module router_fsm_nch #(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 2,
  parameter int WAIT_LIMIT = 8
) (
  input logic             clk,
  input logic             rst,
  router_fsm_nch_if.slave bus
);
  localparam int CW = WAIT_LIMIT > 0 ? $clog2(WAIT_LIMIT + 1) : 1;
  typedef enum logic [3:0] {DA, LFD, LD, FFS, LAF, LP, CPE, WTE, DROP} state_t;
  state_t            state, nxt;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [NUM_CH-1:0] ch_sel, ch_nx, dec;
  logic              addr_ok, sel_empty, sel_sr;
  logic              addr_err, ae_nx, wait_timeout, to_nx;
  assign dec       = NUM_CH'(1) << bus.data_in;
  assign addr_ok   = {1'b0, bus.data_in} < (ADDR_W + 1)'(NUM_CH);
  assign sel_empty = |(bus.fifo_empty & ch_sel);
  assign sel_sr    = |(bus.soft_reset & ch_sel);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= DA;
      cnt          <= '0;
      ch_sel       <= '0;
      addr_err     <= 1'b0;
      wait_timeout <= 1'b0;
    end else begin
      state        <= nxt;
      cnt          <= cnt_nx;
      ch_sel       <= ch_nx;
      addr_err     <= ae_nx;
      wait_timeout <= to_nx;
    end
  end
  always_comb begin
    nxt    = state;
    cnt_nx = cnt;
    ch_nx  = ch_sel;
    ae_nx  = 1'b0;
    to_nx  = 1'b0;
    if (state != DA && state != DROP && sel_sr) nxt = DA;
    else
      case (state)
        DA:
          if (bus.pkt_valid) begin
            if (!addr_ok) begin
              nxt   = DROP;
              ae_nx = 1'b1;
            end else begin
              ch_nx  = dec;
              cnt_nx = '0;
              nxt    = |(bus.fifo_empty & dec) ? LFD : WTE;
            end
          end
        LFD:  nxt = LD;
        LD:   nxt = bus.fifo_full ? FFS : !bus.pkt_valid ? LP : LD;
        FFS:  nxt = bus.fifo_full ? FFS : LAF;
        LAF:  nxt = bus.parity_done ? DA : bus.low_pkt_valid ? LP : LD;
        LP:   nxt = CPE;
        CPE:  nxt = bus.fifo_full ? FFS : DA;
        WTE:
          if (sel_empty) nxt = LFD;
          else if (WAIT_LIMIT > 0 && cnt == CW'(WAIT_LIMIT - 1)) begin
            nxt   = DROP;
            to_nx = 1'b1;
          end else cnt_nx = cnt + CW'(!(&cnt));
        DROP: nxt = bus.pkt_valid ? DROP : DA;
        default: nxt = DA;
      endcase
  end
  assign bus.busy          = state inside {LFD, FFS, LAF, LP, CPE, WTE};
  assign bus.detect_add    = state == DA;
  assign bus.lfd_state     = state == LFD;
  assign bus.ld_state      = state == LD;
  assign bus.laf_state     = state == LAF;
  assign bus.full_state    = state == FFS;
  assign bus.rst_int_reg   = state == CPE;
  assign bus.write_enb_reg = state inside {LD, LAF, LP};
  assign bus.drop_state    = state == DROP;
  assign bus.ch_sel        = ch_sel;
  assign bus.addr_err      = addr_err;
  assign bus.wait_timeout  = wait_timeout;
endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: directed and random stimulus against a packet-level reference model of the router FSM
module tb_router_fsm_nch;
  localparam int NUM_CH = 3, ADDR_W = 2, WAIT_LIMIT = 8;
  localparam int M_DA = 0, M_LFD = 1, M_LD = 2, M_FFS = 3, M_LAF = 4, M_LP = 5, M_CPE = 6, M_WTE = 7, M_DROP = 8;
  logic clk = 1'b0, rst = 1'b0;
  int checks = 0, errors = 0;
  int m_st, m_ch, m_wait;
  bit m_ae, m_to;
  router_fsm_nch_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus ();
  router_fsm_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // {busy, detect_add, lfd, ld, laf, full, rst_int, write_enb, drop}
  function automatic logic [8:0] exp_flags(int s);
    return {s == M_LFD || s == M_FFS || s == M_LAF || s == M_LP || s == M_CPE || s == M_WTE,
            s == M_DA, s == M_LFD, s == M_LD, s == M_LAF, s == M_FFS, s == M_CPE,
            s == M_LD || s == M_LAF || s == M_LP, s == M_DROP};
  endfunction
  task automatic check_all(string tag);
    chk({tag, ".flags"}, 32'({bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
        bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.drop_state}), 32'(exp_flags(m_st)));
    chk({tag, ".ch_sel"}, 32'(bus.ch_sel), m_ch < 0 ? 32'd0 : 32'd1 << m_ch);
    chk({tag, ".addr_err"}, 32'(bus.addr_err), 32'(m_ae));
    chk({tag, ".wait_timeout"}, 32'(bus.wait_timeout), 32'(m_to));
  endtask
  task automatic m_reset();
    m_st = M_DA; m_ch = -1; m_wait = 0; m_ae = 0; m_to = 0;
  endtask
  task automatic model_step();
    int a = int'(bus.data_in);
    int n = m_st;
    m_ae = 0; m_to = 0;
    if (m_st != M_DA && m_st != M_DROP && m_ch >= 0 && bus.soft_reset[m_ch]) n = M_DA;
    else if (m_st == M_DA) begin
      if (bus.pkt_valid && a >= NUM_CH) begin n = M_DROP; m_ae = 1; end
      else if (bus.pkt_valid) begin
        m_ch = a; m_wait = 0;
        n = bus.fifo_empty[a] ? M_LFD : M_WTE;
      end
    end
    else if (m_st == M_LFD) n = M_LD;
    else if (m_st == M_LD) n = bus.fifo_full ? M_FFS : (bus.pkt_valid ? M_LD : M_LP);
    else if (m_st == M_FFS) n = bus.fifo_full ? M_FFS : M_LAF;
    else if (m_st == M_LAF) n = bus.parity_done ? M_DA : (bus.low_pkt_valid ? M_LP : M_LD);
    else if (m_st == M_LP) n = M_CPE;
    else if (m_st == M_CPE) n = bus.fifo_full ? M_FFS : M_DA;
    else if (m_st == M_WTE) begin
      if (bus.fifo_empty[m_ch]) n = M_LFD;
      else if (WAIT_LIMIT > 0 && m_wait == WAIT_LIMIT - 1) begin n = M_DROP; m_to = 1; end
      else m_wait++;
    end
    else if (m_st == M_DROP) n = bus.pkt_valid ? M_DROP : M_DA;
    m_st = n;
  endtask
  task automatic drive(bit pv, int din, int emp, bit full, bit pd, bit lpv, int sr);
    bus.pkt_valid = pv; bus.data_in = ADDR_W'(din); bus.fifo_empty = NUM_CH'(emp);
    bus.fifo_full = full; bus.parity_done = pd; bus.low_pkt_valid = lpv; bus.soft_reset = NUM_CH'(sr);
  endtask
  task automatic cyc(string tag);
    @(posedge clk);
    model_step();
    #1 check_all(tag);
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #12 check_all("reset");
    chk("reset.detect_add", 32'(bus.detect_add), 32'd1);
    rst = 1'b1;
    // normal packet to channel 0
    drive(1, 0, 3'b001, 0, 0, 0, 0);
    cyc("t1");
    chk("t1.lfd_latency", 32'(bus.lfd_state), 32'd1);
    for (int i = 0; i < 3; i++) cyc("t1");
    bus.pkt_valid = 0;
    for (int i = 0; i < 3; i++) cyc("t1");
    chk("t1.back_to_da", 32'(bus.detect_add), 32'd1);
    // FIFO-full stall on channel 1
    drive(1, 1, 3'b010, 0, 0, 0, 0);
    cyc("t2"); cyc("t2");
    bus.fifo_full = 1;
    for (int i = 0; i < 3; i++) cyc("t2");
    chk("t2.busy_ffs", 32'(bus.busy), 32'd1);
    chk("t2.ch_sel_stable", 32'(bus.ch_sel), 32'b010);
    drive(1, 1, 3'b010, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc("t2");
    bus.pkt_valid = 0;
    cyc("t2");
    // invalid address dropped
    drive(1, 3, 3'b111, 0, 0, 0, 0);
    cyc("t3");
    chk("t3.addr_err", 32'(bus.addr_err), 32'd1);
    for (int i = 0; i < 4; i++) cyc("t3");
    chk("t3.no_write", 32'(bus.write_enb_reg), 32'd0);
    bus.pkt_valid = 0;
    cyc("t3");
    cyc("t3");
    // wait-till-empty timeout
    drive(1, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cyc("t4");
    chk("t4.timeout", 32'(bus.wait_timeout), 32'd1);
    for (int i = 0; i < 3; i++) cyc("t4");
    bus.pkt_valid = 0;
    cyc("t4");
    // FIFO empties during wait, then per-channel soft reset
    drive(1, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("t5");
    bus.fifo_empty = 3'b100;
    cyc("t5");
    chk("t5.lfd", 32'(bus.lfd_state), 32'd1);
    cyc("t5");
    bus.soft_reset = 3'b001;
    cyc("t5");
    chk("t5.other_sr", 32'(bus.ld_state), 32'd1);
    bus.soft_reset = 3'b100;
    cyc("t5");
    chk("t5.own_sr", 32'(bus.detect_add), 32'd1);
    // asynchronous reset during FFS
    drive(1, 0, 3'b001, 0, 0, 0, 0);
    cyc("t6"); cyc("t6");
    bus.fifo_full = 1;
    cyc("t6"); cyc("t6");
    #2 rst = 1'b0;
    m_reset();
    #1 check_all("t6.async");
    #1 rst = 1'b1;
    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            {$urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0});
      cyc("rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
